// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchronizer, single mid-bit sample per bit, and a
// rdy/clr_rdy handshake with sticky framing and overrun flags.
`timescale 1ns/1ps
module uart_rx #(
   parameter int BAUD_DIV = 2604
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       RX,
   input  logic       clr_rdy,
   output logic [7:0] rx_data,
   output logic       rdy,
   output logic       frm_err,
   output logic       ovr_err
);

   localparam int CNT_W = $clog2(BAUD_DIV);
   localparam int HALF  = BAUD_DIV / 2;
   localparam logic [CNT_W-1:0] MID_LAST = CNT_W'(HALF - 1);
   localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(BAUD_DIV - 1);

   if (BAUD_DIV < 8) begin : g_bad_div
      $error("uart_rx: BAUD_DIV must be at least 8");
   end

   typedef enum logic [2:0] {
      WAIT_HI,
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   state_t           state;
   logic             rx_meta;
   logic             rx_s;
   logic [CNT_W-1:0] baud_cnt;
   logic [3:0]       bit_cnt;
   logic [7:0]       shift_reg;
   logic             at_mid;
   logic             at_bit;

   // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= RX;
         rx_s    <= rx_meta;
      end
   end

   assign at_mid = (baud_cnt == MID_LAST);
   assign at_bit = (baud_cnt == BIT_LAST);

   // Flag clears from clr_rdy come first so a set event later in the same cycle wins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= WAIT_HI;
         baud_cnt  <= '0;
         bit_cnt   <= '0;
         shift_reg <= '0;
         rx_data   <= '0;
         rdy       <= 1'b0;
         frm_err   <= 1'b0;
         ovr_err   <= 1'b0;
      end else begin
         baud_cnt <= baud_cnt + CNT_W'(1);

         if (clr_rdy) begin
            rdy     <= 1'b0;
            frm_err <= 1'b0;
            ovr_err <= 1'b0;
         end

         unique case (state)
            WAIT_HI: begin
               if (rx_s) begin
                  state    <= IDLE;
                  baud_cnt <= '0;
               end
            end

            IDLE: begin
               if (!rx_s) begin
                  state    <= START;
                  baud_cnt <= '0;
               end
            end

            START: begin
               if (at_mid) begin
                  baud_cnt <= '0;
                  if (rx_s) begin
                     state <= IDLE;
                  end else begin
                     state   <= DATA;
                     bit_cnt <= '0;
                  end
               end
            end

            DATA: begin
               if (at_bit) begin
                  baud_cnt  <= '0;
                  shift_reg <= {rx_s, shift_reg[7:1]};
                  bit_cnt   <= bit_cnt + 4'd1;
                  if (bit_cnt == 4'd7) begin
                     state <= STOP;
                  end
               end
            end

            STOP: begin
               if (at_bit) begin
                  baud_cnt <= '0;
                  if (rx_s) begin
                     rx_data <= shift_reg;
                     rdy     <= 1'b1;
                     if (rdy && !clr_rdy) begin
                        ovr_err <= 1'b1;
                     end
                     state <= IDLE;
                  end else begin
                     frm_err <= 1'b1;
                     state   <= WAIT_HI;
                  end
               end
            end

            default: begin
               state    <= WAIT_HI;
               baud_cnt <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: a full-rate instance for latency and glitch timing,
// a fast instance for handshake, error, reset and randomized frames against a frame-level model.
`timescale 1ns/1ps
module tb_uart_rx;

   localparam int BIG_DIV   = 2604;
   localparam int SMALL_DIV = 20;
   localparam int BIG_LAT   = BIG_DIV / 2 + 9 * BIG_DIV;
   // Negedge index, counted from the start edge, whose following posedge is the stop sample.
   localparam int SMALL_COIN = SMALL_DIV / 2 + 9 * SMALL_DIV + 2;

   logic clk     = 1'b0;
   logic rst     = 1'b1;
   logic rx_line = 1'b1;
   logic use_big = 1'b1;
   logic clr_rdy = 1'b0;

   logic       rx_big, rx_small, clr_big, clr_small;
   logic [7:0] big_data, small_data, obs_data;
   logic       big_rdy, big_frm, big_ovr;
   logic       small_rdy, small_frm, small_ovr;
   logic       obs_rdy, obs_frm, obs_ovr;

   assign rx_big    = use_big ? rx_line : 1'b1;
   assign rx_small  = use_big ? 1'b1 : rx_line;
   assign clr_big   = use_big & clr_rdy;
   assign clr_small = ~use_big & clr_rdy;
   assign obs_data  = use_big ? big_data : small_data;
   assign obs_rdy   = use_big ? big_rdy : small_rdy;
   assign obs_frm   = use_big ? big_frm : small_frm;
   assign obs_ovr   = use_big ? big_ovr : small_ovr;

   uart_rx #(.BAUD_DIV(BIG_DIV)) dut_big (
      .clk(clk), .rst(rst), .RX(rx_big), .clr_rdy(clr_big),
      .rx_data(big_data), .rdy(big_rdy), .frm_err(big_frm), .ovr_err(big_ovr)
   );

   uart_rx #(.BAUD_DIV(SMALL_DIV)) dut_small (
      .clk(clk), .rst(rst), .RX(rx_small), .clr_rdy(clr_small),
      .rx_data(small_data), .rdy(small_rdy), .frm_err(small_frm), .ovr_err(small_ovr)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0] m_data = 8'h00;
   logic       m_rdy  = 1'b0;
   logic       m_frm  = 1'b0;
   logic       m_ovr  = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic check_outputs(input string tag);
      check({tag, "_data"}, 32'(obs_data), 32'(m_data));
      check({tag, "_rdy"},  32'(obs_rdy),  32'(m_rdy));
      check({tag, "_frm"},  32'(obs_frm),  32'(m_frm));
      check({tag, "_ovr"},  32'(obs_ovr),  32'(m_ovr));
   endtask

   task automatic model_reset();
      m_data = 8'h00;
      m_rdy  = 1'b0;
      m_frm  = 1'b0;
      m_ovr  = 1'b0;
   endtask

   task automatic model_clear();
      m_rdy = 1'b0;
      m_frm = 1'b0;
      m_ovr = 1'b0;
   endtask

   // One frame as seen by the consumer: an acknowledge during the frame retires the old byte first.
   task automatic model_frame(input logic [7:0] b, input logic stop_ok, input logic acked);
      if (acked) model_clear();
      if (stop_ok) begin
         m_ovr  = m_ovr | m_rdy;
         m_rdy  = 1'b1;
         m_data = b;
      end else begin
         m_frm = 1'b1;
      end
   endtask

   task automatic idle(input int n);
      rx_line = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_clr();
      clr_rdy = 1'b1;
      @(negedge clk);
      clr_rdy = 1'b0;
      model_clear();
   endtask

   // Drives one frame cycle by cycle from a negedge; clr_at pulses clr_rdy, rst_at aborts with reset.
   task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int clr_at,
                             input int rst_at, output int lat);
      logic [9:0] bits;
      int div;
      div  = use_big ? BIG_DIV : SMALL_DIV;
      bits = {stop_bit, b, 1'b0};
      lat  = -1;
      for (int c = 0; c < 10 * div; c++) begin
         if (c == rst_at) begin
            clr_rdy = 1'b0;
            rst     = 1'b1;
            return;
         end
         rx_line = bits[c / div];
         clr_rdy = (c == clr_at);
         @(negedge clk);
         if (obs_rdy && lat < 0) lat = c + 1;
      end
      clr_rdy = 1'b0;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int lat;
      logic [7:0] b;
      logic stop_ok;
      int mode, clr_at, gap;

      repeat (3) @(negedge clk);
      use_big = 1'b1;
      check_outputs("reset_big");
      use_big = 1'b0;
      check_outputs("reset_small");
      use_big = 1'b1;
      rst = 1'b0;
      idle(10);

      // Full-rate frame: latency window is two synchronizer clocks plus the allowed +-2.
      send_frame(8'hA5, 1'b1, -1, -1, lat);
      model_frame(8'hA5, 1'b1, 1'b0);
      check("a5_latency_in_window", 32'(lat >= BIG_LAT && lat <= BIG_LAT + 4), 32'd1);
      check_outputs("a5");
      idle(5);
      pulse_clr();
      check_outputs("a5_ack");

      // Low pulse shorter than half a bit is a false start.
      rx_line = 1'b0;
      repeat (500) @(negedge clk);
      idle(BIG_DIV);
      check_outputs("glitch");
      send_frame(8'h3C, 1'b1, -1, -1, lat);
      model_frame(8'h3C, 1'b1, 1'b0);
      check_outputs("after_glitch_3c");
      pulse_clr();

      use_big = 1'b0;
      model_reset();
      idle(2 * SMALL_DIV);

      // Zero idle gap between frames; the second frame's start bit carries the acknowledge.
      send_frame(8'h00, 1'b1, -1, -1, lat);
      model_frame(8'h00, 1'b1, 1'b0);
      check_outputs("b2b_00");
      send_frame(8'hFF, 1'b1, 0, -1, lat);
      model_frame(8'hFF, 1'b1, 1'b1);
      check_outputs("b2b_ff");
      pulse_clr();

      // Framing error, line stuck low, then recovery once the line is high again.
      send_frame(8'h5A, 1'b0, -1, -1, lat);
      model_frame(8'h5A, 1'b0, 1'b0);
      rx_line = 1'b0;
      repeat (3 * SMALL_DIV) @(negedge clk);
      check_outputs("frm_5a");
      idle(SMALL_DIV);
      send_frame(8'h81, 1'b1, -1, -1, lat);
      model_frame(8'h81, 1'b1, 1'b0);
      check_outputs("after_frm_81");
      pulse_clr();

      // Overrun, then an acknowledge landing on the stop sample itself.
      send_frame(8'h11, 1'b1, -1, -1, lat);
      model_frame(8'h11, 1'b1, 1'b0);
      send_frame(8'h22, 1'b1, -1, -1, lat);
      model_frame(8'h22, 1'b1, 1'b0);
      check_outputs("ovr_22");
      send_frame(8'h33, 1'b1, SMALL_COIN, -1, lat);
      model_frame(8'h33, 1'b1, 1'b1);
      check_outputs("coincident_33");

      // Reset in the middle of data bit 4 discards the partial byte at once.
      send_frame(8'h96, 1'b1, -1, 5 * SMALL_DIV + SMALL_DIV / 2, lat);
      #1;
      model_reset();
      check_outputs("mid_frame_rst");
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      idle(SMALL_DIV);
      send_frame(8'hC3, 1'b1, -1, -1, lat);
      model_frame(8'hC3, 1'b1, 1'b0);
      check_outputs("after_rst_c3");

      // Random bytes, stop bits, acknowledge placement and idle gaps.
      for (int i = 0; i < 40; i++) begin
         b       = 8'($urandom);
         stop_ok = ($urandom_range(0, 5) != 0);
         mode    = $urandom_range(0, 2);
         clr_at  = (mode == 0) ? -1 : (mode == 1) ? 0 : SMALL_COIN;
         send_frame(b, stop_ok, clr_at, -1, lat);
         model_frame(b, stop_ok, mode != 0);
         check_outputs($sformatf("rand%0d", i));
         if (!stop_ok) begin
            gap = $urandom_range(0, SMALL_DIV);
            repeat (gap) @(negedge clk);
            idle($urandom_range(4, SMALL_DIV));
         end else begin
            idle($urandom_range(0, SMALL_DIV));
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
